// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard controller bus: pipeline status in, stall/flush controls out.
// master = pipeline side, slave = hazard controller.
interface pipeline_hazard_ctrl_if #(
    parameter int PC_W  = 7,
    parameter int REG_W = 5,
    parameter int CNT_W = 16
);
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_uses_rt;
    logic             ex_mem_read;
    logic [REG_W-1:0] ex_dst;
    logic             m_branch;
    logic             m_zero;
    logic [PC_W-1:0]  m_pc_branch;
    logic             m_mem_req;
    logic             mem_ready;

    logic             pc_write;
    logic             pc_src;
    logic [PC_W-1:0]  pc_target;
    logic             if_id_write;
    logic             if_id_flush;
    logic             id_ex_write;
    logic             id_ex_bubble;
    logic             ex_m_write;
    logic             ex_m_bubble;
    logic             m_wb_bubble;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_dst,
        output m_branch, m_zero, m_pc_branch, m_mem_req, mem_ready,
        input  pc_write, pc_src, pc_target, if_id_write, if_id_flush,
        input  id_ex_write, id_ex_bubble, ex_m_write, ex_m_bubble,
        input  m_wb_bubble, mem_err, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_dst,
        input  m_branch, m_zero, m_pc_branch, m_mem_req, mem_ready,
        output pc_write, pc_src, pc_target, if_id_write, if_id_flush,
        output id_ex_write, id_ex_bubble, ex_m_write, ex_m_bubble,
        output m_wb_bubble, mem_err, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline.
// Priority: memory wait > taken branch > load-use.
module pipeline_hazard_ctrl #(
    parameter int PC_W        = 7,
    parameter int REG_W       = 5,
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 15
) (
    input logic                  clk,
    input logic                  rst,
    pipeline_hazard_ctrl_if.slave bus
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

    typedef enum logic {
        RUN,
        MEM_WAIT
    } state_t;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic              mem_err_q, mem_err_d;

    logic lu, br, mw;
    logic freeze, do_br, do_lu;
    logic stall_inc, flush_inc;

    // Raw hazard conditions from the stage status.
    always_comb begin
        lu = bus.ex_mem_read
           & (bus.ex_dst != REG_W'(0))
           & ((bus.ex_dst == bus.id_rs)
              | (bus.id_uses_rt & (bus.ex_dst == bus.id_rt)));
        br = bus.m_branch & bus.m_zero;
        mw = bus.m_mem_req & ~bus.mem_ready;
    end

    // Next-state and action selection; reset forces idle actions.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = mem_err_q;
        freeze     = 1'b0;
        do_br      = 1'b0;
        do_lu      = 1'b0;
        stall_inc  = 1'b0;
        flush_inc  = 1'b0;
        if (!rst) begin
            unique case (state_q)
                RUN: begin
                    if (mw) begin
                        freeze     = 1'b1;
                        wait_cnt_d = WAIT_W'(1);
                        stall_inc  = 1'b1;
                        state_d    = MEM_WAIT;
                    end else if (br) begin
                        do_br     = 1'b1;
                        flush_inc = 1'b1;
                    end else if (lu) begin
                        do_lu     = 1'b1;
                        stall_inc = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    // A dropped request counts as completion.
                    if (!mw) begin
                        state_d = RUN;
                    end else if (wait_cnt_q == WAIT_MAX) begin
                        mem_err_d = 1'b1;
                        state_d   = RUN;
                    end else begin
                        freeze     = 1'b1;
                        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                        stall_inc  = 1'b1;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    // Saturating statistics counters.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_inc && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (flush_inc && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    // State, wait counter, statistics and sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            mem_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            mem_err_q   <= mem_err_d;
        end
    end

    assign bus.pc_write     = ~(freeze | do_lu);
    assign bus.pc_src       = do_br;
    assign bus.pc_target    = do_br ? bus.m_pc_branch : PC_W'(0);
    assign bus.if_id_write  = ~(freeze | do_lu);
    assign bus.if_id_flush  = do_br;
    assign bus.id_ex_write  = ~freeze;
    assign bus.id_ex_bubble = do_br | do_lu;
    assign bus.ex_m_write   = ~freeze;
    assign bus.ex_m_bubble  = do_br;
    assign bus.m_wb_bubble  = freeze;
    assign bus.mem_err      = mem_err_q;
    assign bus.stall_cnt    = stall_cnt_q;
    assign bus.flush_cnt    = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl.
// Second instance with CNT_W=2 covers counter saturation.
module tb_pipeline_hazard_ctrl;

    localparam logic [8:0] IDLE   = 9'b101010100;
    localparam logic [8:0] FREEZE = 9'b000000001;
    localparam logic [8:0] LU     = 9'b000011100;
    localparam logic [8:0] BR     = 9'b111111110;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.PC_W(7), .REG_W(5), .CNT_W(16)) bus ();
    pipeline_hazard_ctrl_if #(.PC_W(7), .REG_W(5), .CNT_W(2))  sbus ();

    pipeline_hazard_ctrl #(
        .PC_W(7), .REG_W(5), .CNT_W(16), .MEM_TIMEOUT(15)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    pipeline_hazard_ctrl #(
        .PC_W(7), .REG_W(5), .CNT_W(2), .MEM_TIMEOUT(15)
    ) dut_sat (
        .clk(clk),
        .rst(rst),
        .bus(sbus)
    );

    function automatic logic [8:0] ctl();
        return {bus.pc_write, bus.pc_src, bus.if_id_write,
                bus.if_id_flush, bus.id_ex_write, bus.id_ex_bubble,
                bus.ex_m_write, bus.ex_m_bubble, bus.m_wb_bubble};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        bus.id_rs = '0; bus.id_rt = '0; bus.id_uses_rt = 1'b0;
        bus.ex_mem_read = 1'b0; bus.ex_dst = '0;
        bus.m_branch = 1'b0; bus.m_zero = 1'b0; bus.m_pc_branch = '0;
        bus.m_mem_req = 1'b0; bus.mem_ready = 1'b0;
    endtask

    task automatic clr_s();
        sbus.id_rs = '0; sbus.id_rt = '0; sbus.id_uses_rt = 1'b0;
        sbus.ex_mem_read = 1'b0; sbus.ex_dst = '0;
        sbus.m_branch = 1'b0; sbus.m_zero = 1'b0; sbus.m_pc_branch = '0;
        sbus.m_mem_req = 1'b0; sbus.mem_ready = 1'b0;
    endtask

    task automatic set_lu();
        bus.ex_mem_read = 1'b1; bus.ex_dst = 5'd3; bus.id_rs = 5'd3;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.m_mem_req = 1'b1; bus.mem_ready = 1'b0;
        set_lu();
        cyc(); cyc(); #3;
        checks++;
        if (ctl() !== IDLE) begin
            errors++; $display("FAIL reset_outputs got %b exp %b", ctl(), IDLE);
        end
        checks++;
        if (bus.stall_cnt !== 16'd0 || bus.flush_cnt !== 16'd0 || bus.mem_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_regs got stall=%0d flush=%0d err=%b exp 0 0 0",
                     bus.stall_cnt, bus.flush_cnt, bus.mem_err);
        end
        cyc(); rst = 1'b0; clr(); #3;
        checks++;
        if (ctl() !== IDLE) begin
            errors++; $display("FAIL post_reset_idle got %b exp %b", ctl(), IDLE);
        end
    endtask

    task automatic test_load_use();
        cyc(); set_lu(); #3;
        checks++;
        if (ctl() !== LU) begin
            errors++; $display("FAIL lu_stall got %b exp %b", ctl(), LU);
        end
        cyc(); clr(); #3;
        checks++;
        if (ctl() !== IDLE || bus.stall_cnt !== 16'd1) begin
            errors++;
            $display("FAIL lu_after got ctl=%b stall=%0d exp %b 1", ctl(), bus.stall_cnt, IDLE);
        end
    endtask

    task automatic test_no_hazard();
        cyc(); bus.ex_mem_read = 1'b1; bus.ex_dst = 5'd0; bus.id_rs = 5'd0; #3;
        checks++;
        if (ctl() !== IDLE) begin
            errors++; $display("FAIL lu_r0 got %b exp %b", ctl(), IDLE);
        end
        cyc(); bus.ex_dst = 5'd4; bus.id_rs = 5'd1; bus.id_rt = 5'd4;
        bus.id_uses_rt = 1'b0; #3;
        checks++;
        if (ctl() !== IDLE) begin
            errors++; $display("FAIL lu_rt_unused got %b exp %b", ctl(), IDLE);
        end
        cyc(); bus.id_uses_rt = 1'b1; #3;
        checks++;
        if (ctl() !== LU) begin
            errors++; $display("FAIL lu_rt_used got %b exp %b", ctl(), LU);
        end
        cyc(); clr(); #3;
        checks++;
        if (bus.stall_cnt !== 16'd2) begin
            errors++; $display("FAIL lu_rt_count got %0d exp 2", bus.stall_cnt);
        end
    endtask

    task automatic test_branch();
        cyc(); set_lu();
        bus.m_branch = 1'b1; bus.m_zero = 1'b1; bus.m_pc_branch = 7'h2A; #3;
        checks++;
        if (ctl() !== BR || bus.pc_target !== 7'h2A) begin
            errors++;
            $display("FAIL br_over_lu got %b tgt=%h exp %b 2a", ctl(), bus.pc_target, BR);
        end
        cyc(); bus.m_zero = 1'b0; #3;
        checks++;
        if (ctl() !== LU || bus.pc_target !== 7'h00 || bus.flush_cnt !== 16'd1) begin
            errors++;
            $display("FAIL br_not_taken got %b tgt=%h flush=%0d exp %b 00 1",
                     ctl(), bus.pc_target, bus.flush_cnt, LU);
        end
        cyc(); clr(); #3;
        checks++;
        if (bus.stall_cnt !== 16'd3) begin
            errors++; $display("FAIL br_stall_count got %0d exp 3", bus.stall_cnt);
        end
    endtask

    task automatic test_back_to_back();
        cyc(); bus.m_branch = 1'b1; bus.m_zero = 1'b1; bus.m_pc_branch = 7'h11; #3;
        checks++;
        if (ctl() !== BR || bus.pc_target !== 7'h11) begin
            errors++; $display("FAIL b2b_first got %b tgt=%h exp %b 11", ctl(), bus.pc_target, BR);
        end
        cyc(); bus.m_pc_branch = 7'h7F; #3;
        checks++;
        if (ctl() !== BR || bus.pc_target !== 7'h7F) begin
            errors++; $display("FAIL b2b_second got %b tgt=%h exp %b 7f", ctl(), bus.pc_target, BR);
        end
        cyc(); clr(); #3;
        checks++;
        if (bus.flush_cnt !== 16'd3 || bus.pc_target !== 7'h00 || ctl() !== IDLE) begin
            errors++;
            $display("FAIL b2b_after got flush=%0d tgt=%h ctl=%b exp 3 00 %b",
                     bus.flush_cnt, bus.pc_target, ctl(), IDLE);
        end
    endtask

    task automatic test_mem_wait();
        for (int i = 0; i < 3; i++) begin
            cyc();
            if (i == 0) begin
                bus.m_mem_req = 1'b1; bus.mem_ready = 1'b0;
            end
            #3;
            checks++;
            if (ctl() !== FREEZE) begin
                errors++; $display("FAIL mw_freeze%0d got %b exp %b", i, ctl(), FREEZE);
            end
        end
        cyc(); bus.mem_ready = 1'b1; set_lu();
        bus.m_branch = 1'b1; bus.m_zero = 1'b1; bus.m_pc_branch = 7'h55; #3;
        checks++;
        if (ctl() !== IDLE) begin
            errors++; $display("FAIL mw_release got %b exp %b", ctl(), IDLE);
        end
        cyc(); clr(); #3;
        checks++;
        if (bus.stall_cnt !== 16'd6 || bus.mem_err !== 1'b0 || bus.flush_cnt !== 16'd3) begin
            errors++;
            $display("FAIL mw_counts got stall=%0d err=%b flush=%0d exp 6 0 3",
                     bus.stall_cnt, bus.mem_err, bus.flush_cnt);
        end
        cyc(); bus.m_mem_req = 1'b1; #3;
        checks++;
        if (ctl() !== FREEZE) begin
            errors++; $display("FAIL mw_drop_enter got %b exp %b", ctl(), FREEZE);
        end
        cyc(); bus.m_mem_req = 1'b0; #3;
        checks++;
        if (ctl() !== IDLE) begin
            errors++; $display("FAIL mw_drop_release got %b exp %b", ctl(), IDLE);
        end
        cyc(); #3;
        checks++;
        if (bus.stall_cnt !== 16'd7 || ctl() !== IDLE) begin
            errors++; $display("FAIL mw_drop_after got stall=%0d ctl=%b exp 7 %b",
                               bus.stall_cnt, ctl(), IDLE);
        end
    endtask

    task automatic test_timeout();
        for (int i = 1; i <= 15; i++) begin
            cyc();
            if (i == 1) begin
                bus.m_mem_req = 1'b1; bus.mem_ready = 1'b0;
            end
            #3;
            checks++;
            if (ctl() !== FREEZE) begin
                errors++; $display("FAIL to_freeze%0d got %b exp %b", i, ctl(), FREEZE);
            end
        end
        cyc(); #3;
        checks++;
        if (ctl() !== IDLE || bus.mem_err !== 1'b0) begin
            errors++; $display("FAIL to_release got %b err=%b exp %b 0", ctl(), bus.mem_err, IDLE);
        end
        cyc(); clr(); #3;
        checks++;
        if (bus.mem_err !== 1'b1 || bus.stall_cnt !== 16'd22) begin
            errors++; $display("FAIL to_err got err=%b stall=%0d exp 1 22",
                               bus.mem_err, bus.stall_cnt);
        end
        cyc(); cyc(); #3;
        checks++;
        if (bus.mem_err !== 1'b1 || ctl() !== IDLE) begin
            errors++; $display("FAIL to_sticky got err=%b ctl=%b exp 1 %b", bus.mem_err, ctl(), IDLE);
        end
    endtask

    task automatic test_reset_mid_wait();
        cyc(); bus.m_mem_req = 1'b1; bus.mem_ready = 1'b0; #3;
        checks++;
        if (ctl() !== FREEZE) begin
            errors++; $display("FAIL rw_enter got %b exp %b", ctl(), FREEZE);
        end
        cyc(); #3;
        checks++;
        if (ctl() !== FREEZE) begin
            errors++; $display("FAIL rw_wait got %b exp %b", ctl(), FREEZE);
        end
        cyc(); rst = 1'b1; #3;
        checks++;
        if (ctl() !== IDLE) begin
            errors++; $display("FAIL rw_in_reset got %b exp %b", ctl(), IDLE);
        end
        cyc(); rst = 1'b0; clr(); set_lu(); bus.m_mem_req = 1'b1; bus.mem_ready = 1'b1; #3;
        checks++;
        if (ctl() !== LU) begin
            errors++; $display("FAIL rw_state_run got %b exp %b", ctl(), LU);
        end
        checks++;
        if (bus.stall_cnt !== 16'd0 || bus.flush_cnt !== 16'd0 || bus.mem_err !== 1'b0) begin
            errors++;
            $display("FAIL rw_cleared got stall=%0d flush=%0d err=%b exp 0 0 0",
                     bus.stall_cnt, bus.flush_cnt, bus.mem_err);
        end
        cyc(); clr();
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 5; i++) begin
            cyc();
            sbus.ex_mem_read = 1'b1; sbus.ex_dst = 5'd5; sbus.id_rs = 5'd5;
        end
        cyc(); clr_s(); #3;
        checks++;
        if (sbus.stall_cnt !== 2'd3) begin
            errors++; $display("FAIL sat_stall got %0d exp 3", sbus.stall_cnt);
        end
    endtask

    initial begin
        clr();
        clr_s();
        test_reset();
        test_load_use();
        test_no_hazard();
        test_branch();
        test_back_to_back();
        test_mem_wait();
        test_timeout();
        test_reset_mid_wait();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
